// File: rtl/jtag_tap_registers.sv
// jtag_tap_registers: IR plus BYPASS/IDCODE/USER data registers driven by the decoded TAP state
module jtag_tap_registers #(
  parameter int IR_WIDTH = 4,
  parameter logic [31:0] IDCODE_VALUE = 32'h1500_1687,
  parameter int USER_DR_WIDTH = 8,
  parameter logic [IR_WIDTH-1:0] INSTR_IDCODE = 'h1,
  parameter logic [IR_WIDTH-1:0] INSTR_USER = 'h8
) (
  input  logic                     tck,
  input  logic                     reset,
  input  logic [3:0]               state,
  input  logic                     tdi,
  output logic                     tdo,
  output logic                     tdo_en,
  output logic [IR_WIDTH-1:0]      ir_out,
  output logic                     sel_bypass,
  output logic                     sel_idcode,
  output logic                     sel_user,
  input  logic [USER_DR_WIDTH-1:0] user_dr_in,
  output logic [USER_DR_WIDTH-1:0] user_dr_out,
  output logic                     user_update
);
  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR,
    UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tap_state_t;
  localparam logic [IR_WIDTH-1:0] IR_CAP = 'b01;
  logic [IR_WIDTH-1:0]      ir_shift;
  logic                     bypass_sr;
  logic [31:0]              idcode_sr;
  logic [USER_DR_WIDTH-1:0] user_sr;
  logic [USER_DR_WIDTH-1:0] user_shifted;
  logic                     cap_dr;
  logic                     sh_dr;
  assign sel_idcode = ir_out == INSTR_IDCODE;
  assign sel_user   = ir_out == INSTR_USER;
  assign sel_bypass = !sel_idcode && !sel_user;
  assign cap_dr = state == CAP_DR;
  assign sh_dr  = state == SH_DR;
  assign tdo_en = sh_dr || state == SH_IR;
  // built this way so a one-bit USER register still shifts correctly
  always_comb begin
    user_shifted = user_sr >> 1;
    user_shifted[USER_DR_WIDTH-1] = tdi;
  end
  always_comb begin
    tdo = state == SH_IR ? ir_shift[0] :
          !sh_dr         ? 1'b0 :
          sel_idcode     ? idcode_sr[0] :
          sel_user       ? user_sr[0] : bypass_sr;
  end
  always_ff @(posedge tck) begin
    if (reset || state == TLR) begin
      ir_out      <= INSTR_IDCODE;
      ir_shift    <= '0;
      bypass_sr   <= 1'b0;
      idcode_sr   <= IDCODE_VALUE;
      user_sr     <= '0;
      user_update <= 1'b0;
      if (reset) user_dr_out <= '0;
    end else begin
      user_update <= state == UPD_DR && sel_user;
      if (state == CAP_IR) ir_shift <= IR_CAP;
      if (state == SH_IR) ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};
      if (state == UPD_IR) ir_out <= ir_shift;
      if (sel_bypass && (cap_dr || sh_dr)) bypass_sr <= sh_dr && tdi;
      if (sel_idcode && cap_dr) idcode_sr <= IDCODE_VALUE;
      if (sel_idcode && sh_dr) idcode_sr <= {tdi, idcode_sr[31:1]};
      if (sel_user && cap_dr) user_sr <= user_dr_in;
      if (sel_user && sh_dr) user_sr <= user_shifted;
      if (sel_user && state == UPD_DR) user_dr_out <= user_sr;
    end
  end
endmodule

// File: tb/tb_jtag_tap_registers.sv
// tb_jtag_tap_registers: directed scans through IR, BYPASS, IDCODE and USER registers
module tb_jtag_tap_registers;
  logic       tck = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] state = 4'h0;
  logic       tdi = 1'b0;
  logic       tdo, tdo_en;
  logic [3:0] ir_out;
  logic       sel_bypass, sel_idcode, sel_user;
  logic [7:0] user_dr_in = 8'h00;
  logic [7:0] user_dr_out;
  logic       user_update;
  int total = 0;
  int bad = 0;
  logic       obs_tdo, obs_en;
  logic [31:0] bits;
  logic [3:0]  irbits;
  logic        en_all, pause_ok;

  jtag_tap_registers dut (
    .tck(tck), .reset(reset), .state(state), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
    .ir_out(ir_out), .sel_bypass(sel_bypass), .sel_idcode(sel_idcode), .sel_user(sel_user),
    .user_dr_in(user_dr_in), .user_dr_out(user_dr_out), .user_update(user_update)
  );

  always #5 tck = ~tck;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // present state/tdi, record tdo as seen by the coming edge, then step past that edge
  task automatic tick(input logic [3:0] st, input logic d);
    state = st;
    tdi = d;
    #1;
    obs_tdo = tdo;
    obs_en = tdo_en;
    @(posedge tck);
    #1;
  endtask

  task automatic shift_dr(input int n, input logic [31:0] din, input int base);
    for (int i = 0; i < n; i++) begin
      tick(4'h4, din[i]);
      bits[base+i] = obs_tdo;
      en_all = en_all & obs_en;
    end
  endtask

  task automatic ir_scan(input logic [3:0] v);
    tick(4'h2, 1'b0);
    tick(4'h9, 1'b0);
    tick(4'hA, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(4'hB, v[i]);
      irbits[i] = obs_tdo;
    end
    tick(4'hC, 1'b0);
    tick(4'hF, 1'b0);
    tick(4'h1, 1'b0);
  endtask

  initial begin
    @(negedge tck);
    tick(4'h0, 1'b0);
    chk("reset_ir", 32'(ir_out), 32'h1);
    chk("reset_sel_idcode", 32'(sel_idcode), 32'h1);
    chk("reset_sel_bypass", 32'(sel_bypass), 32'h0);
    chk("reset_user_dr_out", 32'(user_dr_out), 32'h0);
    chk("reset_user_update", 32'(user_update), 32'h0);
    chk("reset_tdo_en", 32'(tdo_en), 32'h0);
    reset = 1'b0;
    tick(4'h1, 1'b0);
    tick(4'h2, 1'b0);
    tick(4'h3, 1'b0);
    bits = '0;
    en_all = 1'b1;
    shift_dr(32, 32'h0, 0);
    chk("idcode_stream", bits, 32'h1500_1687);
    chk("idcode_tdo_en", 32'(en_all), 32'h1);
    tick(4'h5, 1'b0);
    tick(4'h8, 1'b0);
    chk("idcode_upd_no_pulse", 32'(user_update), 32'h0);
    tick(4'h1, 1'b0);

    ir_scan(4'hF);
    chk("ir_capture_tdo", 32'(irbits), 32'h1);
    chk("ir_out_f", 32'(ir_out), 32'hF);
    chk("sel_bypass_f", 32'({sel_bypass, sel_idcode, sel_user}), 32'b100);

    tick(4'h2, 1'b0);
    tick(4'h3, 1'b0);
    bits = '0;
    en_all = 1'b1;
    shift_dr(4, 32'b1101, 0);
    chk("bypass_delay", bits, 32'b1010);
    tick(4'h5, 1'b0);
    tick(4'h8, 1'b0);
    chk("bypass_upd_out", 32'(user_dr_out), 32'h0);
    chk("bypass_upd_pulse", 32'(user_update), 32'h0);
    tick(4'h1, 1'b0);

    ir_scan(4'h8);
    chk("ir_out_user", 32'(ir_out), 32'h8);
    chk("sel_user", 32'({sel_bypass, sel_idcode, sel_user}), 32'b001);
    user_dr_in = 8'hA5;
    tick(4'h2, 1'b0);
    tick(4'h3, 1'b0);
    bits = '0;
    en_all = 1'b1;
    shift_dr(8, 32'h3C, 0);
    chk("user_capture_stream", bits, 32'hA5);
    tick(4'h5, 1'b0);
    chk("user_out_before_upd", 32'(user_dr_out), 32'h0);
    tick(4'h8, 1'b0);
    chk("user_out_after_upd", 32'(user_dr_out), 32'h3C);
    chk("user_update_pulse", 32'(user_update), 32'h1);
    tick(4'h1, 1'b0);
    chk("user_update_drop", 32'(user_update), 32'h0);

    user_dr_in = 8'h5A;
    tick(4'h2, 1'b0);
    tick(4'h3, 1'b0);
    bits = '0;
    en_all = 1'b1;
    shift_dr(3, 32'hC3, 0);
    tick(4'h5, 1'b1);
    pause_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(4'h6, 1'(i));
      pause_ok = pause_ok & !obs_en & !obs_tdo;
    end
    chk("pause_tdo_idle", 32'(pause_ok), 32'h1);
    tick(4'h7, 1'b0);
    shift_dr(5, 32'(8'hC3 >> 3), 3);
    chk("pause_resume_stream", bits, 32'h5A);
    chk("pause_tdo_en", 32'(en_all), 32'h1);
    tick(4'h5, 1'b0);
    chk("pause_out_held", 32'(user_dr_out), 32'h3C);
    tick(4'h8, 1'b0);
    chk("pause_out_upd", 32'(user_dr_out), 32'hC3);
    tick(4'h1, 1'b0);

    tick(4'h2, 1'b0);
    tick(4'h9, 1'b0);
    tick(4'hA, 1'b0);
    tick(4'hB, 1'b1);
    tick(4'hB, 1'b0);
    reset = 1'b1;
    tick(4'hB, 1'b1);
    state = 4'h0;
    #1;
    chk("midshift_reset_ir", 32'(ir_out), 32'h1);
    chk("midshift_reset_tdo_en", 32'(tdo_en), 32'h0);
    chk("midshift_reset_user_out", 32'(user_dr_out), 32'h0);
    tick(4'h0, 1'b0);
    reset = 1'b0;
    tick(4'h1, 1'b0);
    ir_scan(4'h8);
    chk("post_reset_ir_capture", 32'(irbits), 32'h1);
    tick(4'h2, 1'b0);
    tick(4'h3, 1'b0);
    bits = '0;
    shift_dr(8, 32'h69, 0);
    tick(4'h5, 1'b0);
    tick(4'h8, 1'b0);
    chk("reload_user_out", 32'(user_dr_out), 32'h69);
    tick(4'h0, 1'b0);
    chk("tlr_ir", 32'(ir_out), 32'h1);
    chk("tlr_user_out_held", 32'(user_dr_out), 32'h69);
    chk("tlr_user_update", 32'(user_update), 32'h0);
    chk("tlr_tdo_en", 32'(tdo_en), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
